// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot-time ROM-to-SRAM copy engine.
package boot_loader_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int FIFO_DEPTH = 2;
endpackage

// File: rtl/boot_loader_fifo2.sv
// Two-entry synchronous FIFO; simultaneous push and pop are allowed when full.
module boot_loader_fifo2
  import boot_loader_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [1:0]   count_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] mem0_q, mem0_d, mem1_q, mem1_d;
  logic [1:0]   cnt_q, cnt_d;

  always_comb begin
    mem0_d = mem0_q;
    mem1_d = mem1_q;
    cnt_d  = cnt_q;
    if (pop_i && cnt_q != 2'd0) begin
      mem0_d = mem1_q;
      cnt_d  = cnt_q - 2'd1;
    end
    // push lands behind whatever survives this cycle's pop
    if (push_i && cnt_d < 2'(FIFO_DEPTH)) begin
      if (cnt_d == 2'd0) mem0_d = din_i;
      else               mem1_d = din_i;
      cnt_d = cnt_d + 2'd1;
    end
    if (flush_i) cnt_d = 2'd0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem0_q <= '0;
      mem1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      mem0_q <= mem0_d;
      mem1_q <= mem1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign head_o  = mem0_q;

endmodule

// File: rtl/boot_loader.sv
// Boot copy engine: streams a word range from the boot ROM to a destination
// SRAM port with a running checksum and a done pulse.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SRC_WORDS  = 1024,
  parameter int DST_WORDS  = 4096,
  localparam int SRC_AW = $clog2(SRC_WORDS),
  localparam int DST_AW = $clog2(DST_WORDS),
  localparam int BE_W   = (DATA_WIDTH + 7) / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [SRC_AW-1:0]     src_base_i,
  input  logic [DST_AW-1:0]     dst_base_i,
  input  logic [SRC_AW:0]       len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] checksum_o,
  output logic                  src_req_o,
  output logic                  src_we_o,
  output logic [SRC_AW-1:0]     src_addr_o,
  output logic [DATA_WIDTH-1:0] src_wdata_o,
  output logic [BE_W-1:0]       src_be_o,
  input  logic [DATA_WIDTH-1:0] src_rdata_i,
  output logic                  dst_req_o,
  output logic                  dst_we_o,
  output logic [DST_AW-1:0]     dst_addr_o,
  output logic [DATA_WIDTH-1:0] dst_wdata_o,
  output logic [BE_W-1:0]       dst_be_o,
  input  logic                  dst_gnt_i
);

  localparam int LW = SRC_AW + 1;

  state_e                state_q, state_d;
  logic [LW-1:0]         len_q, len_d, rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [SRC_AW-1:0]     src_addr_q, src_addr_d;
  logic [DST_AW-1:0]     dst_addr_q, dst_addr_d;
  logic [DATA_WIDTH-1:0] cks_q, cks_d;
  logic                  inflight_q, inflight_d;

  logic                  run, pop, rd_issue, fifo_push, fifo_pop, fifo_flush;
  logic [1:0]            fifo_count;
  logic [DATA_WIDTH-1:0] fifo_head, wr_word;
  logic [2:0]            occ;

  boot_loader_fifo2 #(.W(DATA_WIDTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .din_i   (src_rdata_i),
    .pop_i   (fifo_pop),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  // Returning read data bypasses the empty FIFO so the first write
  // goes out in the same cycle the ROM data arrives.
  assign run        = (state_q == RUN);
  assign wr_word    = (fifo_count != 2'd0) ? fifo_head : src_rdata_i;
  assign dst_req_o  = run && !abort_i && (fifo_count != 2'd0 || inflight_q);
  assign pop        = dst_req_o && dst_gnt_i;
  assign occ        = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
  assign rd_issue   = run && !abort_i && (rd_cnt_q < len_q) && (occ < 3'(FIFO_DEPTH));
  assign fifo_pop   = pop && (fifo_count != 2'd0);
  assign fifo_push  = inflight_q && !(pop && fifo_count == 2'd0);
  assign fifo_flush = !run || abort_i;
  assign inflight_d = rd_issue;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    src_addr_d = src_addr_q;
    dst_addr_d = dst_addr_q;
    cks_d      = cks_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          len_d      = len_i;
          src_addr_d = src_base_i;
          dst_addr_d = dst_base_i;
          rd_cnt_d   = '0;
          wr_cnt_d   = '0;
          cks_d      = '0;
          state_d    = (len_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          if (rd_issue) begin
            rd_cnt_d   = rd_cnt_q + LW'(1);
            src_addr_d = (src_addr_q == SRC_AW'(SRC_WORDS - 1)) ? '0 : src_addr_q + SRC_AW'(1);
          end
          if (pop) begin
            wr_cnt_d   = wr_cnt_q + LW'(1);
            dst_addr_d = (dst_addr_q == DST_AW'(DST_WORDS - 1)) ? '0 : dst_addr_q + DST_AW'(1);
            cks_d      = cks_q + wr_word;
            if (wr_cnt_q == len_q - LW'(1)) state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      len_q      <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      src_addr_q <= '0;
      dst_addr_q <= '0;
      cks_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      src_addr_q <= src_addr_d;
      dst_addr_q <= dst_addr_d;
      cks_q      <= cks_d;
      inflight_q <= inflight_d;
    end
  end

  assign busy_o      = run;
  assign done_o      = (state_q == DONE);
  assign checksum_o  = cks_q;
  assign src_req_o   = rd_issue;
  assign src_we_o    = 1'b0;
  assign src_addr_o  = src_addr_q;
  assign src_wdata_o = '0;
  assign src_be_o    = '1;
  assign dst_we_o    = dst_req_o;
  assign dst_addr_o  = dst_addr_q;
  assign dst_wdata_o = wr_word;
  assign dst_be_o    = '1;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: vector table of copies plus abort/reset/start-while-busy sequences.
module tb_boot_loader;
  localparam int DW = 32, SW = 1024, DWD = 4096, SAW = 10, DAW = 12, BEW = 4;

  logic clk, rst, start, abort, gnt;
  logic [SAW-1:0] src_base;
  logic [DAW-1:0] dst_base;
  logic [SAW:0]   len;
  logic busy_o, done_o, src_req_o, src_we_o, dst_req_o, dst_we_o;
  logic [DW-1:0]  checksum_o, src_wdata_o, src_rdata, dst_wdata_o;
  logic [SAW-1:0] src_addr_o;
  logic [DAW-1:0] dst_addr_o;
  logic [BEW-1:0] src_be_o, dst_be_o;

  boot_loader #(.DATA_WIDTH(DW), .SRC_WORDS(SW), .DST_WORDS(DWD)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .src_base_i(src_base), .dst_base_i(dst_base), .len_i(len),
    .busy_o(busy_o), .done_o(done_o), .checksum_o(checksum_o),
    .src_req_o(src_req_o), .src_we_o(src_we_o), .src_addr_o(src_addr_o),
    .src_wdata_o(src_wdata_o), .src_be_o(src_be_o), .src_rdata_i(src_rdata),
    .dst_req_o(dst_req_o), .dst_we_o(dst_we_o), .dst_addr_o(dst_addr_o),
    .dst_wdata_o(dst_wdata_o), .dst_be_o(dst_be_o), .dst_gnt_i(gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] rom [SW];
  always @(posedge clk) if (src_req_o) src_rdata <= rom[src_addr_o];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nsrc, nwr, ndone, done_edge, maxocc;
  logic [DW-1:0] done_cks;
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];
  logic [31:0] rd_addr [64];
  int          wr_edge [64];

  // Outputs are sampled mid-cycle; inputs change 1 time unit after posedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (src_req_o) begin
        if (nsrc < 64) rd_addr[nsrc] = 32'(src_addr_o);
        nsrc++;
      end
      if (dst_req_o && gnt) begin
        if (nwr < 64) begin
          wr_addr[nwr] = 32'(dst_addr_o);
          wr_data[nwr] = dst_wdata_o;
          wr_edge[nwr] = cyc;
        end
        nwr++;
      end
      if (done_o) begin
        ndone++;
        done_edge = cyc;
        done_cks  = checksum_o;
      end
      if (nsrc - nwr > maxocc) maxocc = nsrc - nwr;
    end
  end

  int nchk = 0, nerr = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    nsrc = 0; nwr = 0; ndone = 0; maxocc = 0;
  endtask

  typedef struct {
    logic [SAW-1:0] src;
    logic [DAW-1:0] dst;
    logic [SAW:0]   len;
    bit             alt;
    logic [DW-1:0]  cks;
    int             rel;   // done cycle relative to start, -1 = not checked
  } vec_t;

  vec_t vecs [5];

  task automatic run_vec(input vec_t v, input string tag);
    int t0;
    step();
    clr();
    t0 = cyc;
    start = 1'b1; src_base = v.src; dst_base = v.dst; len = v.len;
    gnt = v.alt ? 1'b0 : 1'b1;
    for (int k = 0; k < 200; k++) begin
      step();
      start = 1'b0;
      if (v.alt) gnt = ~gnt;
      if (ndone > 0) break;
    end
    chk({tag, "_done_cnt"}, 32'(ndone), 32'd1);
    if (v.rel >= 0) chk({tag, "_done_cyc"}, 32'(done_edge - t0), 32'(v.rel));
    chk({tag, "_cks"}, done_cks, v.cks);
    chk({tag, "_nwr"}, 32'(nwr), 32'(v.len));
    chk({tag, "_nrd"}, 32'(nsrc), 32'(v.len));
    chk({tag, "_occ"}, 32'(maxocc <= 2), 32'd1);
    for (int j = 0; j < int'(v.len); j++) begin
      chk({tag, "_rd_addr"}, rd_addr[j], 32'((int'(v.src) + j) % SW));
      chk({tag, "_wr_addr"}, wr_addr[j], 32'((int'(v.dst) + j) % DWD));
      chk({tag, "_wr_data"}, wr_data[j], rom[(int'(v.src) + j) % SW]);
      if (v.rel >= 0) chk({tag, "_wr_cyc"}, 32'(wr_edge[j] - t0), 32'(2 + j));
    end
    gnt = 1'b1;
    step(); step(); step();
    chk({tag, "_cks_hold"}, checksum_o, v.cks);
    chk({tag, "_busy_end"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    int t0, snap;
    for (int i = 0; i < SW; i++) rom[i] = 32'(i * 3 + 7);
    rom[16] = 32'd1; rom[17] = 32'd2; rom[18] = 32'd3; rom[19] = 32'd4;
    vecs[0] = '{src: 10'h010, dst: 12'h100, len: 11'd4, alt: 1'b0, cks: 32'd10,   rel: 6};
    vecs[1] = '{src: 10'h010, dst: 12'h100, len: 11'd4, alt: 1'b1, cks: 32'd10,   rel: -1};
    vecs[2] = '{src: 10'd1022, dst: 12'd4095, len: 11'd3, alt: 1'b0, cks: 32'd6156, rel: 5};
    vecs[3] = '{src: 10'd5,   dst: 12'd7,   len: 11'd0, alt: 1'b0, cks: 32'd0,    rel: 1};
    vecs[4] = '{src: 10'h010, dst: 12'h3f0, len: 11'd1, alt: 1'b1, cks: 32'd1,    rel: -1};

    rst = 1'b1; start = 1'b0; abort = 1'b0; gnt = 1'b1;
    src_base = '0; dst_base = '0; len = '0;
    clr();
    step(); step(); step();
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_src_req", 32'(src_req_o), 32'd0);
    chk("rst_dst_req", 32'(dst_req_o), 32'd0);
    chk("rst_cks", checksum_o, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // start pulse while busy must be ignored
    step(); clr(); t0 = cyc;
    start = 1'b1; src_base = 10'h010; dst_base = 12'h200; len = 11'd4; gnt = 1'b1;
    step(); start = 1'b0;
    step(); start = 1'b1; src_base = '0; dst_base = '0; len = '0;
    step(); start = 1'b0;
    for (int k = 0; k < 50 && ndone == 0; k++) step();
    step(); step(); step();
    chk("busy_start_done_cnt", 32'(ndone), 32'd1);
    chk("busy_start_done_cyc", 32'(done_edge - t0), 32'd6);
    chk("busy_start_nwr", 32'(nwr), 32'd4);
    chk("busy_start_addr3", wr_addr[3], 32'h203);
    chk("busy_start_cks", done_cks, 32'd10);

    // abort after two grants
    step(); clr();
    start = 1'b1; src_base = 10'h010; dst_base = 12'h300; len = 11'd8; gnt = 1'b1;
    step(); start = 1'b0;
    for (int k = 0; k < 50 && nwr < 2; k++) step();
    abort = 1'b1;
    step(); abort = 1'b0;
    chk("abort_busy", 32'(busy_o), 32'd0);
    step();
    snap = nsrc;
    for (int k = 0; k < 6; k++) step();
    chk("abort_nwr", 32'(nwr), 32'd2);
    chk("abort_no_done", 32'(ndone), 32'd0);
    chk("abort_no_rd", 32'(nsrc), 32'(snap));
    chk("abort_cks", checksum_o, 32'd3);
    run_vec(vecs[0], "post_abort");

    // reset while a write is stalled
    step(); clr();
    start = 1'b1; src_base = 10'h010; dst_base = 12'h100; len = 11'd8; gnt = 1'b1;
    step(); start = 1'b0;
    for (int k = 0; k < 50 && nwr < 2; k++) step();
    gnt = 1'b0;
    step(); step();
    chk("pre_rst_req", 32'(dst_req_o), 32'd1);
    chk("pre_rst_cks", checksum_o, 32'd3);
    rst = 1'b1;
    step();
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_done", 32'(done_o), 32'd0);
    chk("mid_rst_src_req", 32'(src_req_o), 32'd0);
    chk("mid_rst_dst_req", 32'(dst_req_o), 32'd0);
    chk("mid_rst_cks", checksum_o, 32'd0);
    rst = 1'b0; gnt = 1'b1;
    run_vec(vecs[0], "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
